// File: rtl/l2_prefetch_responder.sv
// L2-side prefetch responder: latch a line request, probe tags, refill on a
// miss, then pulse complete with hit/miss status. L1 traffic always wins.
module l2_prefetch_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int L2cache_width = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_pref_l2cache,
  input  logic                  type_pref_l2cache,
  input  logic [ADDR_WIDTH-1:0] addr_pref_l2cache,
  output logic                  complete_l2cache_pref,
  output logic                  hit_l2cache_pref,
  output logic                  miss_l2cache_pref,
  input  logic                  l1_busy,
  input  logic                  l1_miss,
  output logic                  probe_req,
  output logic [ADDR_WIDTH-1:0] probe_addr,
  output logic                  probe_type,
  input  logic                  probe_valid,
  input  logic                  probe_hit,
  output logic                  mem_rd_valid,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic                  mem_rvalid_pref,
  input  logic                  mem_rlast_pref,
  output logic                  err_l2cache_pref
);
  localparam int OFS = L2cache_width + 2;
  localparam logic [ADDR_WIDTH-1:0]    LINE_MASK = {ADDR_WIDTH{1'b1}} << OFS;
  localparam logic [L2cache_width-1:0] LAST_BEAT = {L2cache_width{1'b1}};

  typedef enum logic [2:0] {IDLE, PROBE, MREQ, MWAIT, RESP} state_t;

  state_t                   state, nstate;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     type_q, hit_q, miss_q, err_q;
  logic [L2cache_width-1:0] beat_q;
  logic                     accept, set_hit, set_miss, set_err, beat_inc;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nstate;
  end

  // next state, flag updates and outputs
  always_comb begin
    nstate   = state;
    accept   = 1'b0;
    set_hit  = 1'b0;
    set_miss = 1'b0;
    set_err  = 1'b0;
    beat_inc = 1'b0;
    case (state)
      IDLE: if (req_pref_l2cache && !l1_busy) begin
        accept = 1'b1;
        nstate = PROBE;
      end
      PROBE: begin
        if (probe_valid) begin
          set_miss = l1_miss;
          if (probe_hit) begin
            set_hit = 1'b1;
            nstate  = RESP;
          end else begin
            nstate  = l1_miss ? RESP : MREQ;
          end
        end else if (l1_miss) begin
          set_miss = 1'b1;
          nstate   = RESP;
        end
      end
      MREQ: begin
        set_miss = l1_miss;
        if (mem_rd_ready)  nstate = MWAIT;
        else if (l1_miss)  nstate = RESP;
      end
      MWAIT: begin
        set_miss = l1_miss;
        if (mem_rvalid_pref) begin
          beat_inc = 1'b1;
          // completion follows the beat count; rlast is only cross-checked
          if (beat_q == LAST_BEAT) begin
            nstate  = RESP;
            set_err = !mem_rlast_pref;
          end else begin
            set_err = mem_rlast_pref;
          end
        end
      end
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
    complete_l2cache_pref = (state == RESP);
    hit_l2cache_pref      = (state == RESP) && hit_q;
    miss_l2cache_pref     = (state == RESP) && miss_q;
    probe_req             = (state == PROBE);
    mem_rd_valid          = (state == MREQ);
    probe_addr            = addr_q;
    mem_rd_addr           = addr_q;
    probe_type            = type_q;
    err_l2cache_pref      = err_q;
  end

  // latched request, sticky flags and refill beat counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      type_q <= 1'b0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      err_q  <= 1'b0;
      beat_q <= '0;
    end else begin
      err_q <= err_q | set_err;
      if (accept) begin
        addr_q <= addr_pref_l2cache & LINE_MASK;
        type_q <= type_pref_l2cache;
        hit_q  <= 1'b0;
        miss_q <= 1'b0;
        beat_q <= '0;
      end else begin
        hit_q  <= hit_q | set_hit;
        miss_q <= miss_q | set_miss;
        if (beat_inc) beat_q <= beat_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_l2_prefetch_responder.sv
// Bench for l2_prefetch_responder: table of transactions driven by a reactive
// requester/tag/memory model; expected responses go through a scoreboard queue.
module tb_l2_prefetch_responder;
  logic        clk, rstn;
  logic        req, typ, l1_busy, l1_miss, probe_valid, probe_hit;
  logic        mem_rd_ready, rvalid, rlast;
  logic [31:0] addr;
  logic        complete, hit, miss, probe_req, probe_type, mem_rd_valid, err;
  logic [31:0] probe_addr, mem_rd_addr;

  l2_prefetch_responder #(.ADDR_WIDTH(32), .L2cache_width(3)) dut (
    .clk(clk), .rstn(rstn),
    .req_pref_l2cache(req), .type_pref_l2cache(typ), .addr_pref_l2cache(addr),
    .complete_l2cache_pref(complete), .hit_l2cache_pref(hit), .miss_l2cache_pref(miss),
    .l1_busy(l1_busy), .l1_miss(l1_miss),
    .probe_req(probe_req), .probe_addr(probe_addr), .probe_type(probe_type),
    .probe_valid(probe_valid), .probe_hit(probe_hit),
    .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rvalid_pref(rvalid), .mem_rlast_pref(rlast), .err_l2cache_pref(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 none, 1 l1_miss before probe_valid, 2 l1_miss at beat 3,
  //       3 l1_miss with probe_valid, 4 l1_miss in MREQ before ready,
  //       5 l1_miss with mem_rd_ready
  typedef struct {
    logic [31:0] addr; logic typ; int busy; int pd; logic phit; int mode;
    int rdly; logic gaps; int rlast; logic e_hit, e_miss, e_err, e_mem; int rst_beat;
  } vec_t;

  typedef struct {
    logic hit, miss, err, mem, typ; logic [31:0] addr;
  } exp_t;

  vec_t tbl[12];
  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  logic saw_mem = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req_v, $time);
  endtask

  // scoreboard side: compare every completion against the queued expectation
  always @(negedge clk) begin
    if (!rstn) saw_mem <= 1'b0;
    else begin
      if (!complete) chk("idle_hit_miss_zero", {hit, miss}, 2'b00);
      if (mem_rd_valid) begin
        saw_mem <= 1'b1;
        if (q.size() > 0) chk("mem_rd_addr", mem_rd_addr, q[0].addr);
      end
      if (complete) begin
        if (q.size() == 0) chk("unexpected_complete", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("hit", hit, e.hit);
          chk("miss", miss, e.miss);
          chk("err", err, e.err);
          chk("probe_addr", probe_addr, e.addr);
          chk("probe_type", probe_type, e.typ);
          chk("mem_rd_seen", saw_mem | mem_rd_valid, e.mem);
        end
        saw_mem <= 1'b0;
      end
    end
  end

  task automatic clr_in();
    probe_valid = 0; probe_hit = 0; mem_rd_ready = 0; rvalid = 0; rlast = 0; l1_miss = 0;
  endtask

  task automatic run(input vec_t v);
    int pw = 0, md = 0, k = 0, b = 0, term = -100;
    bit inmw = 0, done = 0;
    @(posedge clk); #1;
    if (v.rst_beat < 0)
      q.push_back('{hit: v.e_hit, miss: v.e_miss, err: v.e_err, mem: v.e_mem,
                    typ: v.typ, addr: v.addr & 32'hFFFF_FFE0});
    req = 1; typ = v.typ; addr = v.addr; l1_busy = (v.busy > 0);
    for (int it = 1; it <= 150 && !done; it++) begin
      @(posedge clk); #1;
      clr_in();
      if (it <= v.busy) chk("busy_no_probe", probe_req, 0);
      if (v.busy > 0 && it == v.busy + 1) chk("probe_after_busy", probe_req, 1);
      if (it == v.busy) l1_busy = 0;
      if (complete) begin
        chk("complete_latency", it, term + 1);
        req = 0; done = 1;
      end else if (probe_req) begin
        if (v.mode == 1 && pw == 0) begin
          l1_miss = 1; term = it;
        end else if (pw >= v.pd) begin
          probe_valid = 1; probe_hit = v.phit; term = it;
          if (v.mode == 3) l1_miss = 1;
        end
        pw++;
      end else if (mem_rd_valid) begin
        if (v.mode == 4 && md == 0) begin
          l1_miss = 1; term = it;
        end else if (md == v.rdly) begin
          mem_rd_ready = 1; inmw = 1;
          if (v.mode == 5) l1_miss = 1;
        end
        md++;
      end else if (inmw) begin
        if (!(v.gaps && (k % 2 == 1))) begin
          if (b == v.rst_beat) begin
            chk("err_before_reset", err, v.e_err);
            rstn = 0; req = 0; l1_busy = 0;
            #1;
            chk("reset_outputs_zero",
                {complete, hit, miss, probe_req, probe_type, mem_rd_valid, err, probe_addr, mem_rd_addr},
                '0);
            q.delete();
            @(posedge clk); #1;
            rstn = 1; done = 1;
          end else begin
            rvalid = 1; rlast = (b == v.rlast);
            if (v.mode == 2 && b == 3) l1_miss = 1;
            if (b == 7) term = it;
            b++;
          end
        end
        k++;
      end
    end
    if (!done) begin
      chk("timeout", 1, 0);
      req = 0; l1_busy = 0; clr_in();
    end
  endtask

  initial begin
    //          addr          typ busy pd phit mode rdly gaps rlast hit miss err mem rst
    tbl[0]  = '{32'h0000_1234, 0, 0, 0, 1, 0, 0, 0, 7, 1, 0, 0, 0, -1};
    tbl[1]  = '{32'h0000_1234, 0, 0, 0, 0, 0, 3, 1, 7, 0, 0, 0, 1, -1};
    tbl[2]  = '{32'h00AB_CDEF, 1, 0, 2, 1, 1, 0, 0, 7, 0, 1, 0, 0, -1};
    tbl[3]  = '{32'h8000_0040, 1, 0, 0, 0, 2, 1, 0, 7, 0, 1, 0, 1, -1};
    tbl[4]  = '{32'h0000_0FFF, 0, 5, 0, 1, 0, 0, 0, 7, 1, 0, 0, 0, -1};
    tbl[5]  = '{32'h1234_5678, 1, 0, 2, 1, 3, 0, 0, 7, 1, 1, 0, 0, -1};
    tbl[6]  = '{32'h0000_0020, 0, 0, 0, 0, 3, 0, 0, 7, 0, 1, 0, 0, -1};
    tbl[7]  = '{32'hDEAD_BEEF, 1, 0, 1, 0, 4, 2, 0, 7, 0, 1, 0, 1, -1};
    tbl[8]  = '{32'h0000_4444, 0, 0, 0, 0, 5, 0, 1, 7, 0, 1, 0, 1, -1};
    tbl[9]  = '{32'h0000_5000, 1, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1, 1, -1};
    tbl[10] = '{32'h0000_6000, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1, 1,  2};
    tbl[11] = '{32'hFFFF_FFFF, 1, 0, 0, 1, 0, 0, 0, 7, 1, 0, 0, 0, -1};

    rstn = 0; req = 0; typ = 0; addr = '0; l1_busy = 0;
    clr_in();
    #3;
    chk("reset_state",
        {complete, hit, miss, probe_req, probe_type, mem_rd_valid, err, probe_addr, mem_rd_addr}, '0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1;

    for (int i = 0; i < 12; i++) run(tbl[i]);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
